// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide unit.
//
// Multiply uses a 32-step shift-add over operand magnitudes into a 64-bit
// product accumulator. Divide uses 32-step restoring radix-2 division. The
// sign fix-up is applied once, in FIN. Divide-by-zero and signed overflow
// skip CALC and go straight to FIN with pre-loaded results.
//
// Optional feature: define MULDIV_FAST_MUL_EN to compute all multiply ops
// with one 33x33 signed combinational multiply (IDLE -> FIN directly).
//
// Ports:
//   clk     - sole clock, rising edge
//   rst_n   - asynchronous active-low reset
//   A, B    - operands rs1 / rs2 (32 bit)
//   funct3  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   start   - request, sampled only in IDLE
//   kill    - flush; aborts the operation, no done pulse
//   result  - operation result, held until the next completion
//   busy    - high while in CALC or FIN
//   done    - one-cycle pulse marking result valid
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  funct3,
  input  logic        start,
  input  logic        kill,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  state_t      state_r, state_nx_s;
  logic [4:0]  cnt_r;
  logic [2:0]  op_r;
  logic [31:0] opa_r;      // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] acc_r;      // product accumulator; low half holds multiplier
  logic [31:0] rem_r;
  logic [31:0] quo_r;      // quotient; starts as the dividend magnitude
  logic        neg_r;      // negate product / quotient
  logic        rem_neg_r;  // negate remainder (sign of dividend)
  logic [31:0] result_r;
  logic        busy_r;
  logic        done_r;

  logic        a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic        div0_s, ovf_s, fast_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_part_s, div_diff_s;
  logic        div_ge_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s, rem_fix_s, sel_s;

  // Operand decode for the request presented in IDLE.
  always_comb begin
    a_signed_s = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    b_signed_s = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    a_neg_s    = a_signed_s & A[31];
    b_neg_s    = b_signed_s & B[31];
    a_mag_s    = a_neg_s ? (32'd0 - A) : A;
    b_mag_s    = b_neg_s ? (32'd0 - B) : B;
    div0_s     = funct3[2] && (B == 32'd0);
    ovf_s      = ((funct3 == 3'd4) || (funct3 == 3'd6)) &&
                 (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_prod_s;
  assign fast_s      = ~funct3[2];
  assign fast_prod_s = $signed({a_signed_s & A[31], A}) * $signed({b_signed_s & B[31], B});
`else
  assign fast_s = 1'b0;
`endif

  // One iteration step of both datapaths.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opa_r} : 33'd0);
    div_part_s = {rem_r, quo_r[31]};
    div_diff_s = div_part_s - {1'b0, opa_r};
    // Partial remainder is always < 2*divisor, so bit 32 of the difference
    // is set exactly when the trial subtraction underflows.
    div_ge_s   = ~div_diff_s[32];
  end

  // Sign fix-up and result selection, consumed in FIN.
  always_comb begin
    prod_fix_s = neg_r ? (64'd0 - acc_r) : acc_r;
    quo_fix_s  = neg_r ? (32'd0 - quo_r) : quo_r;
    rem_fix_s  = rem_neg_r ? (32'd0 - rem_r) : rem_r;
    sel_s      = 32'd0;
    case (op_r)
      3'd0:                sel_s = prod_fix_s[31:0];
      3'd1, 3'd2, 3'd3:    sel_s = prod_fix_s[63:32];
      3'd4, 3'd5:          sel_s = quo_fix_s;
      3'd6, 3'd7:          sel_s = rem_fix_s;
      default:             sel_s = 32'd0;
    endcase
  end

  // Next-state logic; kill always returns to IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (kill) begin
          state_nx_s = IDLE;
        end else if (start) begin
          state_nx_s = (div0_s || ovf_s || fast_s) ? FIN : CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (kill) begin
          state_nx_s = IDLE;
        end else if (cnt_r == 5'd31) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = CALC;
        end
      end
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      done_r  <= (state_r == FIN) && !kill;
    end
  end

  // Datapath: capture in IDLE, iterate in CALC, load result in FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 5'd0;
      op_r      <= 3'd0;
      opa_r     <= 32'd0;
      acc_r     <= 64'd0;
      rem_r     <= 32'd0;
      quo_r     <= 32'd0;
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
      result_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !kill) begin
            op_r      <= funct3;
            cnt_r     <= 5'd0;
            opa_r     <= funct3[2] ? b_mag_s : a_mag_s;
            acc_r     <= {32'd0, b_mag_s};
            rem_r     <= 32'd0;
            quo_r     <= a_mag_s;
            neg_r     <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            if (div0_s) begin
              quo_r     <= 32'hFFFF_FFFF;
              rem_r     <= A;
              neg_r     <= 1'b0;
              rem_neg_r <= 1'b0;
            end else if (ovf_s) begin
              quo_r     <= 32'h8000_0000;
              rem_r     <= 32'd0;
              neg_r     <= 1'b0;
              rem_neg_r <= 1'b0;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (fast_s) begin
              acc_r <= fast_prod_s[63:0];
              neg_r <= 1'b0;
            end
`endif
          end
        end
        CALC: begin
          if (!kill) begin
            cnt_r <= cnt_r + 5'd1;
            if (op_r[2]) begin
              rem_r <= div_ge_s ? div_diff_s[31:0] : div_part_s[31:0];
              quo_r <= {quo_r[30:0], div_ge_s};
            end else begin
              acc_r <= {mul_sum_s, acc_r[31:1]};
            end
          end
        end
        FIN: begin
          if (!kill) begin
            result_r <= sel_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, randomized
// operations against an arithmetic reference model, kill and reset hazards.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A, B;
  logic [2:0]  funct3;
  logic        start, kill;
  logic [31:0] result;
  logic        busy, done;

  int          checks_cnt = 0;
  int          errors_cnt = 0;
  logic [31:0] last_result;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .funct3 (funct3),
    .start  (start),
    .kill   (kill),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  // Edge index (edge 0 = start sampled) after which done is visible.
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 32'd0) return 1;
    if (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation; scramble inputs (incl. start) while busy.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int n, lat, busy_bad;
    lat = ref_latency(f, a, b);
    funct3 = f; A = a; B = b; start = 1'b1; kill = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    busy_bad = 0;
    check_val({tag, "_done_low"}, {31'd0, done}, 32'd0);
    if (!busy) busy_bad++;
    for (n = 1; n <= 40; n++) begin
      A = $urandom; B = $urandom; funct3 = 3'($urandom_range(0, 7));
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done) break;
      if (!busy) busy_bad++;
    end
    start = 1'b0;
    check_val({tag, "_lat"}, n, lat);
    check_val({tag, "_res"}, result, exp_res);
    check_val({tag, "_busy"}, busy_bad, 32'd0);
    check_val({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
    last_result = exp_res;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          done_seen;

    A = 32'd0; B = 32'd0; funct3 = 3'd0; start = 1'b0; kill = 1'b0;
    last_result = 32'd0;
    #12;
    check_val("rst_result", result, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, back-to-back.
    run_op("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
    run_op("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op("divu",    3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC);
    run_op("remu",    3'd7, 32'hFFFF_FFF9,  32'd2,         32'd1);
    run_op("divu0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF);
    run_op("rem0",    3'd6, 32'd5,          32'd0,         32'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_opnd();
      b = pick_opnd();
      run_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_result(f, a, b));
    end

    // Explicit start with new operands at cycle 5 of DIV 100/7.
    funct3 = 3'd4; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    funct3 = 3'd0; A = 32'd3; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 40 && done_seen == 0; n++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1;
    end
    check_val("ign_start_done", done_seen, 32'd1);
    check_val("ign_start_res", result, 32'd14);
    last_result = 32'd14;

    // Kill at cycle 10 of a DIVU; kill also wins over start in IDLE.
    funct3 = 3'd5; A = $urandom; B = $urandom | 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check_val("kill_busy", {31'd0, busy}, 32'd0);
    check_val("kill_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check_val("kill_start_busy", {31'd0, busy}, 32'd0);
    kill = 1'b0; start = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check_val("kill_quiet", done_seen, 32'd0);
    check_val("kill_res", result, last_result);

    // Asynchronous reset mid-CALC at cycle 20.
    funct3 = 3'd4; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_result", result, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_result = 32'd0;

    // First edge after reset accepts start.
    run_op("post_rst", 3'd7, 32'd100, 32'd7, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port A, input, 32 bits: operand rs1, signed or unsigned per op.
REQ-005 The block SHALL have port B, input, 32 bits: operand rs2, signed or unsigned per op.
REQ-006 The block SHALL have port funct3, input, 3 bits, with this encoding:
- 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU;
- 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-008 The block SHALL have port kill, input, 1 bit: pipeline flush; aborts the operation in progress.
REQ-009 The block SHALL have port result, output, 32 bits: operation result.
REQ-010 The block SHALL have port busy, output, 1 bit: high in CALC and FIN; the pipeline stalls on it.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC and FIN.
REQ-013 IDLE with start=1 and kill=0 SHALL:
- capture funct3, the operand magnitudes, the operand signs and the result-negate flag;
- clear the iteration counter;
- go to CALC.
REQ-014 CALC SHALL run exactly 32 iterations:
- multiply: shift-add, 64-bit product accumulator;
- divide: restoring radix-2, 32-bit quotient and 33-bit partial remainder.
After iteration 32 the FSM SHALL go to FIN.
REQ-015 FIN SHALL apply the sign fix-up and load result, assert done for 1 cycle, then return to IDLE.
REQ-016 Nominal latency SHALL be 34 cycles: start sampled at edge 0; done and result valid in the cycle following edge 33.
REQ-017 Result selection SHALL be:
- MUL: product[31:0];
- MULH, MULHSU, MULHU: product[63:32], with signed×signed, signed×unsigned and unsigned×unsigned operands respectively;
- DIV, DIVU: quotient;
- REM, REMU: remainder.
REQ-018 Signed division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-019 Divide by zero (B=0) SHALL go from IDLE to FIN directly, with done in the cycle following edge 1:
- DIV, DIVU: 0xFFFFFFFF;
- REM, REMU: A.
REQ-020 Signed overflow (DIV or REM with A=0x80000000 and B=0xFFFFFFFF) SHALL go from IDLE to FIN directly:
- DIV: 0x80000000;
- REM: 0.
REQ-021 start SHALL be ignored while busy=1; the captured operands and operation SHALL be unaffected.
REQ-022 kill=1 in any state SHALL force IDLE on the next edge with no done pulse; result holds its previous value.
REQ-023 kill=1 SHALL win over start=1 in the same cycle; the request is dropped.
REQ-024 result SHALL hold its value from FIN until the next FIN.
REQ-025 A start in the cycle right after done SHALL be accepted, giving back-to-back operations.

Reset
REQ-026 rst_n=0 SHALL asynchronously force, at any time including mid-CALC:
- state IDLE, counter 0;
- result 0x00000000, busy 0, done 0;
- all internal datapath registers 0.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-028 With macro MULDIV_FAST_MUL_EN defined:
- MUL, MULH, MULHSU and MULHU SHALL use a single 33×33 signed combinational multiply;
- they SHALL go from IDLE to FIN directly, with done in the cycle following edge 1;
- divide ops SHALL be unchanged.
REQ-029 Without MULDIV_FAST_MUL_EN, multiply ops SHALL use the iterative path with 34-cycle latency and no hardware multiplier.

Verification
REQ-030 Signed multiply: MUL A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB, done pulse at cycle 34 (cycle 2 with macro), busy high for cycles 1-33.
REQ-031 High products:
- MULH A=B=0x80000000 -> 0x40000000;
- MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE;
- MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-032 Signed divide: A=0xFFFFFFF9 (-7), B=2:
- DIV -> 0xFFFFFFFD;
- REM -> 0xFFFFFFFF;
- DIVU -> 0x7FFFFFFC;
- REMU -> 1.
REQ-033 Corner cases:
- DIVU A=5, B=0 -> 0xFFFFFFFF, done at cycle 2;
- REM A=5, B=0 -> 5;
- DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000;
- REM of the same operands -> 0.
REQ-034 Control hazards:
- start with new operands at cycle 5 of DIV 100/7 -> ignored, result 14;
- kill at cycle 10 -> no done, busy low from cycle 11, result unchanged;
- rst_n low at cycle 20 -> all outputs 0 immediately.
